// File: rtl/cache_sa_if.sv
// Bus bundle for cache_sa: read request/response channels, refill write port,
// flash invalidate and the statistics outputs.
interface cache_sa_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 128
);
  // Both read channels transfer on a cycle where valid && ready; a source holds
  // its payload while valid is high and ready is low. The write port has no ready.
  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [ADDR_WIDTH-1:0]   rd_req_addr;
  logic                    rd_rsp_valid;
  logic                    rd_rsp_ready;
  logic [BLOCK_SIZE-1:0]   rd_rsp_data;
  logic                    rd_rsp_hit;
  logic                    wr_valid;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [BLOCK_SIZE-1:0]   wr_data;
  logic [BLOCK_SIZE/8-1:0] wr_we;
  logic                    wr_fill;
  logic                    inv;
  logic [31:0]             stat_hits;
  logic [31:0]             stat_misses;

  modport master (
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    output wr_valid, wr_addr, wr_data, wr_we, wr_fill, inv,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_hit,
    input  stat_hits, stat_misses
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  wr_valid, wr_addr, wr_data, wr_we, wr_fill, inv,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_hit,
    output stat_hits, stat_misses
  );
endinterface

// File: rtl/cache_sa.sv
// N-way set-associative line store with true-LRU replacement, a registered read
// channel and flash invalidate. Define CACHE_SA_STATS_EN for hit/miss counters.
module cache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  cache_sa_if.slave bus
);
  localparam int BYTES = BLOCK_SIZE / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef logic [AGE_W-1:0]            age_t;
  typedef logic [WAYS-1:0][AGE_W-1:0]  ages_t;
  typedef logic [TAG_W-1:0]            tag_t;
  typedef logic [IDX_W-1:0]            idx_t;
  typedef logic [BLOCK_SIZE-1:0]       line_t;

  function automatic ages_t init_ages();
    ages_t a;
    for (int w = 0; w < WAYS; w++) a[w] = age_t'(w);
    return a;
  endfunction

  localparam ages_t AGE_INIT = init_ages();

  logic [WAYS-1:0][BLOCK_SIZE-1:0] data_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]      tag_q  [SETS];
  logic [SETS-1:0][WAYS-1:0]       valid_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;

  logic  rsp_valid_q, rsp_hit_q;
  line_t rsp_data_q;

  idx_t  rd_idx, wr_idx;
  tag_t  rd_tag, wr_tag;
  logic  req_ready, rd_accept, rd_hit, rd_upd;
  age_t  rd_way;
  line_t rd_line;
  ages_t age_rd;

  logic  wr_hit, have_inv, same_set, wr_do;
  age_t  wr_hit_way, inv_way, lru_way, wr_way;
  ages_t age_base, age_wr;
  line_t wr_line;

  logic unused_offset;
  assign unused_offset = ^{bus.rd_req_addr[OFF_W-1:0], bus.wr_addr[OFF_W-1:0]};

  assign rd_idx = bus.rd_req_addr[OFF_W +: IDX_W];
  assign rd_tag = bus.rd_req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign wr_idx = bus.wr_addr[OFF_W +: IDX_W];
  assign wr_tag = bus.wr_addr[ADDR_WIDTH-1 -: TAG_W];

  assign req_ready        = !rsp_valid_q || bus.rd_rsp_ready;
  assign rd_accept        = bus.rd_req_valid && req_ready;
  assign bus.rd_req_ready = req_ready;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_data  = rsp_data_q;
  assign bus.rd_rsp_hit   = rsp_hit_q;

  always_comb begin
    rd_hit  = 1'b0;
    rd_way  = '0;
    rd_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit  = 1'b1;
        rd_way  = age_t'(w);
        rd_line = data_q[rd_idx][w];
      end
    end
  end

  // Read-hit LRU update; feeds the write path so a same-set write sees it first.
  always_comb begin
    rd_upd = rd_accept && rd_hit;
    age_rd = age_q[rd_idx];
    if (rd_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_t'(w) == rd_way) age_rd[w] = '0;
        else if (age_q[rd_idx][w] < age_q[rd_idx][rd_way]) age_rd[w] = age_q[rd_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_hit     = 1'b1;
        wr_hit_way = age_t'(w);
      end
    end
    same_set = rd_upd && (rd_idx == wr_idx);
    age_base = same_set ? age_rd : age_q[wr_idx];
    have_inv = 1'b0;
    inv_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[wr_idx][w]) begin
        have_inv = 1'b1;
        inv_way  = age_t'(w);
      end
    end
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_base[w] == age_t'(WAYS - 1)) lru_way = age_t'(w);
    end
    wr_way = wr_hit ? wr_hit_way : (have_inv ? inv_way : lru_way);
    wr_do  = bus.wr_valid && !bus.inv && (wr_hit || bus.wr_fill);
    age_wr = age_base;
    if (wr_do) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_t'(w) == wr_way) age_wr[w] = '0;
        else if (age_base[w] < age_base[wr_way]) age_wr[w] = age_base[w] + 1'b1;
      end
    end
  end

  // Fills replace the whole line; hits merge only the enabled bytes.
  always_comb begin
    wr_line = bus.wr_data;
    if (wr_hit) begin
      wr_line = data_q[wr_idx][wr_hit_way];
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wr_we[b]) wr_line[b*8 +: 8] = bus.wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      age_q   <= {SETS{AGE_INIT}};
    end else if (bus.inv) begin
      valid_q <= '0;
      age_q   <= {SETS{AGE_INIT}};
    end else begin
      if (rd_upd) age_q[rd_idx] <= age_rd;
      if (wr_do) begin
        age_q[wr_idx]           <= age_wr;
        valid_q[wr_idx][wr_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      data_q[wr_idx][wr_way] <= wr_line;
      tag_q[wr_idx][wr_way]  <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= rd_hit;
      rsp_data_q  <= rd_line;
    end else if (bus.rd_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef CACHE_SA_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (rsp_valid_q && bus.rd_rsp_ready) begin
      if (rsp_hit_q) begin
        if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign bus.stat_hits   = hits_q;
  assign bus.stat_misses = misses_q;
`else
  assign bus.stat_hits   = '0;
  assign bus.stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// Bench for cache_sa: directed steps then random traffic against a recency-list
// reference model of the cache contents.
module tb_cache_sa;
  localparam int ADDR_WIDTH = 32;
  localparam int BLOCK_SIZE = 128;
  localparam int SETS       = 8;
  localparam int WAYS       = 2;
  localparam int BYTES      = BLOCK_SIZE / 8;
  localparam int OFF_W      = 4;
  localparam int IDX_W      = 3;
  localparam int TAG_W      = ADDR_WIDTH - OFF_W - IDX_W;

  typedef logic [BLOCK_SIZE-1:0] line_t;
  typedef logic [BLOCK_SIZE:0]   ent_t;

`ifdef CACHE_SA_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  localparam line_t D_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam line_t D_AM = 128'h0123456789ABCDEF0123456789ABCDAA;
  localparam line_t D0   = 128'h00001111222233334444555566667777;
  localparam line_t D1   = 128'h8888999AAAABBBBCCCCDDDDEEEEFFFF0;
  localparam line_t D2   = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_sa_if #(.ADDR_WIDTH(ADDR_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) bus ();

  cache_sa #(.ADDR_WIDTH(ADDR_WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  ent_t exp_q[$];

  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  line_t            m_data  [SETS][WAYS];
  int               ord     [SETS][WAYS];
  logic [31:0]      m_hits, m_misses;

  task automatic chk(input string tag, input ent_t obs, input ent_t want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic int set_of(input logic [ADDR_WIDTH-1:0] a);
    return int'(a[OFF_W +: IDX_W]);
  endfunction

  function automatic int find_way(input logic [ADDR_WIDTH-1:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[ADDR_WIDTH-1:OFF_W+IDX_W]) return w;
    return -1;
  endfunction

  // ord[s] lists ways from most to least recently used.
  function automatic void touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        ord[s][w]     = w;
      end
  endfunction

  task automatic check_outputs();
    chk("rsp_valid", ent_t'(bus.rd_rsp_valid), ent_t'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("rsp_hit", ent_t'(bus.rd_rsp_hit), ent_t'(exp_q[0][BLOCK_SIZE]));
      chk("rsp_data", ent_t'(bus.rd_rsp_data), ent_t'(exp_q[0][BLOCK_SIZE-1:0]));
    end
    chk("stat_hits", ent_t'(bus.stat_hits), ent_t'(STATS_ON ? m_hits : 32'd0));
    chk("stat_misses", ent_t'(bus.stat_misses), ent_t'(STATS_ON ? m_misses : 32'd0));
  endtask

  task automatic tick();
    bit hs, acc;
    int rs, rw, ws, ww, vw;
    ent_t ent;
    #1;
    chk("req_ready", ent_t'(bus.rd_req_ready), ent_t'((exp_q.size() == 0) || bus.rd_rsp_ready));
    hs  = (exp_q.size() != 0) && bus.rd_rsp_ready;
    acc = bus.rd_req_valid && ((exp_q.size() == 0) || bus.rd_rsp_ready);
    rs  = set_of(bus.rd_req_addr);
    rw  = find_way(bus.rd_req_addr);
    ws  = set_of(bus.wr_addr);
    ww  = find_way(bus.wr_addr);
    if (hs) begin
      if (exp_q[0][BLOCK_SIZE]) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits++;
      end else begin
        if (m_misses != 32'hFFFF_FFFF) m_misses++;
      end
      void'(exp_q.pop_front());
    end
    if (acc) begin
      ent = (rw >= 0) ? {1'b1, m_data[rs][rw]} : '0;
      exp_q.push_back(ent);
      if (rw >= 0) touch(rs, rw);
    end
    if (bus.inv) model_clear();
    else if (bus.wr_valid) begin
      if (ww >= 0) begin
        for (int b = 0; b < BYTES; b++)
          if (bus.wr_we[b]) m_data[ws][ww][b*8 +: 8] = bus.wr_data[b*8 +: 8];
        touch(ws, ww);
      end else if (bus.wr_fill) begin
        vw = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[ws][w]) vw = w;
        if (vw < 0) vw = ord[ws][WAYS-1];
        m_valid[ws][vw] = 1'b1;
        m_tag[ws][vw]   = bus.wr_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
        m_data[ws][vw]  = bus.wr_data;
        touch(ws, vw);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.rd_req_valid = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.inv          = 1'b0;
    bus.rd_rsp_ready = 1'b1;
  endtask

  task automatic do_read(input logic [ADDR_WIDTH-1:0] a);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = a;
    tick();
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_WIDTH-1:0] a, input line_t d,
                          input logic [BYTES-1:0] we, input logic fill);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_we    = we;
    bus.wr_fill  = fill;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    idle();
    bus.rd_req_addr = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_we       = '0;
    bus.wr_fill     = 1'b0;
    model_clear();
    m_hits   = '0;
    m_misses = '0;
    #12;
    chk("reset_req_ready", ent_t'(bus.rd_req_ready), ent_t'(1'b1));
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    do_read(32'h100);
    chk("t1_hit", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));
    chk("t1_data", ent_t'(bus.rd_rsp_data), ent_t'(0));

    do_write(32'h100, D_A, '1, 1'b1);
    do_read(32'h100);
    chk("t2_hit", ent_t'(bus.rd_rsp_hit), ent_t'(1'b1));
    chk("t2_data", ent_t'(bus.rd_rsp_data), ent_t'(D_A));
    do_read(32'h104);
    chk("t2_same_line", ent_t'(bus.rd_rsp_hit), ent_t'(1'b1));

    do_write(32'h100, 128'hAA, 16'h0001, 1'b0);
    do_read(32'h100);
    chk("t3_masked", ent_t'(bus.rd_rsp_data), ent_t'(D_AM));
    do_write(32'h200, D1, '1, 1'b0);
    do_read(32'h200);
    chk("t3_nofill_miss", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));

    bus.inv = 1'b1;
    tick();
    bus.inv = 1'b0;
    do_write(32'h000, D0, '1, 1'b1);
    do_write(32'h080, D1, '1, 1'b1);
    do_read(32'h000);
    do_write(32'h100, D2, '1, 1'b1);
    do_read(32'h000);
    chk("t4_keep_mru", ent_t'(bus.rd_rsp_hit), ent_t'(1'b1));
    do_read(32'h100);
    chk("t4_new_fill", ent_t'(bus.rd_rsp_hit), ent_t'(1'b1));
    do_read(32'h080);
    chk("t4_evicted", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));

    tick();
    bus.rd_rsp_ready = 1'b0;
    do_read(32'h000);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 32'h100;
    tick();
    chk("t5_stall_ready", ent_t'(bus.rd_req_ready), ent_t'(1'b0));
    tick();
    chk("t5_hold_data", ent_t'(bus.rd_rsp_data), ent_t'(D0));
    bus.rd_rsp_ready = 1'b1;
    tick();
    chk("t5_next_data", ent_t'(bus.rd_rsp_data), ent_t'(D2));
    bus.rd_req_valid = 1'b0;

    bus.inv = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 32'h100;
    do_write(32'h300, D1, '1, 1'b1);
    bus.inv = 1'b0;
    bus.rd_req_valid = 1'b0;
    chk("t6_pre_inv_hit", ent_t'(bus.rd_rsp_hit), ent_t'(1'b1));
    do_read(32'h100);
    chk("t6_inv_100", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));
    do_read(32'h300);
    chk("t6_inv_300", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));
    tick();

    for (int n = 0; n < 600; n++) begin
      bus.rd_req_valid = 1'($urandom_range(0, 1));
      bus.rd_req_addr  = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 3)) << 4)
                         | 32'($urandom_range(0, 15));
      bus.rd_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.wr_valid     = 1'($urandom_range(0, 1));
      bus.wr_addr      = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 3)) << 4)
                         | 32'($urandom_range(0, 15));
      bus.wr_data      = {$urandom, $urandom, $urandom, $urandom};
      bus.wr_we        = 16'($urandom);
      bus.wr_fill      = ($urandom_range(0, 3) != 0);
      bus.inv          = ($urandom_range(0, 59) == 0);
      tick();
    end

    idle();
    tick();
    do_write(32'h000, D0, '1, 1'b1);
    bus.rd_rsp_ready = 1'b0;
    do_read(32'h000);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    m_hits   = '0;
    m_misses = '0;
    chk("async_rst_valid", ent_t'(bus.rd_rsp_valid), ent_t'(1'b0));
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_rsp_ready = 1'b1;
    do_read(32'h000);
    chk("rst_lines_lost", ent_t'(bus.rd_rsp_hit), ent_t'(1'b0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised N-way set-associative block cache store; successor to the direct-mapped single-interface cache.
- Adds:
  - generic SETS/WAYS;
  - true-LRU replacement with allocate-on-fill writes;
  - a registered read channel with valid/ready backpressure;
  - flash invalidate.
- Sits between a core-side fetch/LSU front end and the memory refill logic. The refill logic drives the write port.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BLOCK_SIZE, 128, line width in bits. Power of two, >=32.
- SETS, 8, number of sets. Power of two, >=2.
- WAYS, 2, associativity. Power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted when valid&&ready
- rd_req_addr  in  ADDR_WIDTH  read byte address
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  response consumed when valid&&ready
- rd_rsp_data  out  BLOCK_SIZE  hit line data; 0 on miss
- rd_rsp_hit  out  1  lookup hit
- wr_valid  in  1  write strobe; always accepted
- wr_addr  in  ADDR_WIDTH  write byte address
- wr_data  in  BLOCK_SIZE  write data
- wr_we  in  BLOCK_SIZE/8  byte enables, used on hit
- wr_fill  in  1  1 = allocate on miss; 0 = update only on hit
- inv  in  1  invalidate all lines
- stat_hits  out  32  read hit count (feature only)
- stat_misses  out  32  read miss count (feature only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Address split:
  - offset = log2(BLOCK_SIZE/8) LSBs;
  - index = next log2(SETS) bits;
  - tag = remaining MSBs.
- Reset values:
  - all valid bits 0;
  - LRU age of way i = i in every set;
  - rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_hit=0;
  - stat counters 0.
  - The data/tag arrays are not reset.
- Read channel:
  - rd_req_ready = !rd_rsp_valid || rd_rsp_ready (combinational; 1 during reset).
  - Lookup uses array state at the accept edge, before any same-edge write or inv takes effect.
  - The response is registered and appears with 1-cycle latency.
  - While rd_rsp_valid && !rd_rsp_ready, data and hit are held stable.
  - Back-to-back accepts give one response per cycle.
- Hit: the tag matches a valid way. At most one way may match; the write logic guarantees no duplicates.
- Write:
  - Hit: bytes with wr_we=1 are updated in the hit way; others are unchanged.
  - Miss with wr_fill=1: victim = lowest-index invalid way, else the way with age WAYS-1. The whole line is written with wr_data (wr_we ignored), the tag is written, and valid is set.
  - Miss with wr_fill=0: no state change.
- LRU (per set, log2(WAYS)-bit ages, ages always a permutation of 0..WAYS-1):
  - On access to way w with age a: way w age := 0, and every way with age < a increments.
  - Accesses are read hits (at accept) and write hits or fills.
  - Read and write to the same set in the same cycle: the read update is applied first, then the write update.
- inv:
  - At the next edge: clear all valid bits and restore initial ages.
  - A same-cycle write is dropped.
  - A same-cycle read is still served from the pre-invalidate state.
- Reset mid-operation: a pending response is discarded (rd_rsp_valid -> 0 asynchronously). Lines are lost.

Optional Feature:
- Macro: CACHE_SA_STATS_EN.
- Defined:
  - stat_hits/stat_misses increment on each response handshake (rd_rsp_valid && rd_rsp_ready) according to rd_rsp_hit;
  - both saturate at 0xFFFFFFFF;
  - both clear on reset only (not on inv).
- Undefined: the ports remain present and are tied to 0; no counter logic.

Test Plan:
1. Reset; read 0x100 -> next cycle rd_rsp_valid=1, rd_rsp_hit=0, rd_rsp_data=0.
2. Fill write 0x100 with data 0x0123..CDEF (wr_fill=1); read 0x100 -> hit=1, data identical. Read 0x104 (same line) -> hit.
3. Masked write on hit, 0x100 with wr_we=0x0001, wr_data low byte 0xAA -> only byte0=0xAA. Write 0x200 with wr_fill=0 (miss) -> a later read of 0x200 misses.
4. LRU eviction (default params, set 0):
   - Fill 0x000 and 0x080, read 0x000, fill 0x100 -> 0x080 evicted.
   - Reads: 0x000 and 0x100 hit, 0x080 misses.
5. Backpressure: hold rd_rsp_ready=0 for 2 cycles after an accept -> rd_req_ready=0 and response stable. Raise ready -> consumed, and the next request is accepted the same cycle.
6. inv asserted with a same-cycle fill of 0x300 and a read of 0x100 (valid) -> read returns hit. Afterwards 0x100 and 0x300 both miss. With CACHE_SA_STATS_EN: stat_hits=1, stat_misses=2.
